// File: rtl/intr_controller_pkg.sv
// Shared definitions for the interrupt/exception front end: code widths,
// exception code values, FSM state encoding and source bit indices.
package intr_controller_pkg;

  localparam int DEF_HARD_SRC_NUM = 4;
  localparam int DEF_SOFT_SRC_NUM = 4;

  localparam int CODE_HARD_BITS = 3;
  localparam int CODE_SOFT_BITS = 3;

  // Hardware-side codes presented to the vector address decoder.
  typedef enum logic [CODE_HARD_BITS-1:0] {
    HC_NONE     = 3'd0,
    HC_RESET    = 3'd1,
    HC_TIMER    = 3'd2,
    HC_KEYBOARD = 3'd3,
    HC_ETHERNET = 3'd4,
    HC_IO       = 3'd5
  } hard_code_e;

  // Software exception codes presented to the vector address decoder.
  typedef enum logic [CODE_SOFT_BITS-1:0] {
    SC_NONE      = 3'd0,
    SC_ZERODIV   = 3'd1,
    SC_OVERFLOW  = 3'd2,
    SC_UNDERFLOW = 3'd3,
    SC_TRAP      = 3'd4
  } soft_code_e;

  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_REQ_RST = 3'd1,
    ST_IDLE    = 3'd2,
    ST_REQ     = 3'd3,
    ST_SERVICE = 3'd4
  } state_e;

  // Bit positions inside the hard and soft request vectors.
  localparam int SRC_TIMER     = 0;
  localparam int SRC_KEYBOARD  = 1;
  localparam int SRC_ETHERNET  = 2;
  localparam int SRC_IO        = 3;
  localparam int SRC_ZERODIV   = 0;
  localparam int SRC_OVERFLOW  = 1;
  localparam int SRC_UNDERFLOW = 2;
  localparam int SRC_TRAP      = 3;

  // Hard source k maps to code TIMER+k; soft source k maps to ZERODIV+k.
  function automatic hard_code_e hard_code_of(input int idx);
    return hard_code_e'(CODE_HARD_BITS'(int'(HC_TIMER) + idx));
  endfunction

  function automatic soft_code_e soft_code_of(input int idx);
    return soft_code_e'(CODE_SOFT_BITS'(int'(SC_ZERODIV) + idx));
  endfunction

endpackage

// File: rtl/intr_controller_if.sv
// CPU sequencer handshake: request, exception codes, in-service flag and ack.
// The controller drives the master side; the CPU sequencer is the slave.
interface intr_controller_if;
  import intr_controller_pkg::*;

  logic       intr_req;
  logic       intr_ack;
  logic       in_service;
  hard_code_e h_intr_code;
  soft_code_e s_intr_code;

  modport master (
    output intr_req,
    output h_intr_code,
    output s_intr_code,
    output in_service,
    input  intr_ack
  );

  modport slave (
    input  intr_req,
    input  h_intr_code,
    input  s_intr_code,
    input  in_service,
    output intr_ack
  );

endinterface

// File: rtl/intr_controller_priority_enc.sv
// intr_priority_enc: combinational fixed-priority pick among eligible pending
// sources. Hard sources beat soft ones; lower index beats higher index.
// Produces the winner's code (the other code field NONE) and a one-hot winner.
module intr_priority_enc
  import intr_controller_pkg::*;
#(
  parameter int HARD_N = DEF_HARD_SRC_NUM,
  parameter int SOFT_N = DEF_SOFT_SRC_NUM
) (
  input  logic [HARD_N-1:0]        hard_elig,
  input  logic [SOFT_N-1:0]        soft_elig,
  output hard_code_e               hard_code,
  output soft_code_e               soft_code,
  output logic [HARD_N+SOFT_N-1:0] winner
);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    hard_code = HC_NONE;
    soft_code = SC_NONE;
    winner    = '0;
    for (int k = SOFT_N - 1; k >= 0; k--) begin
      if (soft_elig[k]) begin
        hard_code          = HC_NONE;
        soft_code          = soft_code_of(k);
        winner             = '0;
        winner[HARD_N + k] = 1'b1;
      end
    end
    for (int k = HARD_N - 1; k >= 0; k--) begin
      if (hard_elig[k]) begin
        hard_code = hard_code_of(k);
        soft_code = SC_NONE;
        winner    = '0;
        winner[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_controller.sv
// intr_controller: interrupt/exception front end ahead of the vector decoder.
// Latches hardware edges and software exception pulses, arbitrates, and
// presents one code at a time to the CPU with a req/ack handshake, then tracks
// the handler until eret. Issues the RESET code once after reset release.
// Optional feature macro: INTR_SOURCE_MASK_EN adds i_hard_mask (per-source
// hard masking; masked sources still latch and show on o_pending).
module intr_controller
  import intr_controller_pkg::*;
#(
  parameter int HARD_SRC_NUM = DEF_HARD_SRC_NUM,
  parameter int SOFT_SRC_NUM = DEF_SOFT_SRC_NUM
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [HARD_SRC_NUM-1:0]              i_hard_irq,
  input  logic [SOFT_SRC_NUM-1:0]              i_soft_exc,
  input  logic                                 i_intr_en,
`ifdef INTR_SOURCE_MASK_EN
  input  logic [HARD_SRC_NUM-1:0]              i_hard_mask,
`endif
  input  logic                                 i_eret,
  intr_controller_if.master                    cpu,
  output logic [HARD_SRC_NUM+SOFT_SRC_NUM-1:0] o_pending
);

  localparam int SRC_N = HARD_SRC_NUM + SOFT_SRC_NUM;

  state_e                  state_q, state_d;
  logic [HARD_SRC_NUM-1:0] hard_prev_q;
  logic [SRC_N-1:0]        pending_q, pending_d;
  logic [SRC_N-1:0]        winner_q, winner_d;
  logic [SRC_N-1:0]        clr;
  logic                    req_q, req_d;
  logic                    svc_q, svc_d;
  hard_code_e              h_code_q, h_code_d;
  soft_code_e              s_code_q, s_code_d;

  logic [HARD_SRC_NUM-1:0] hard_edge;
  logic [HARD_SRC_NUM-1:0] hard_elig;
  logic [SOFT_SRC_NUM-1:0] soft_elig;
  hard_code_e              enc_h_code;
  soft_code_e              enc_s_code;
  logic [SRC_N-1:0]        enc_winner;

  assign hard_edge = i_hard_irq & ~hard_prev_q;

`ifdef INTR_SOURCE_MASK_EN
  assign hard_elig = pending_q[HARD_SRC_NUM-1:0] & {HARD_SRC_NUM{i_intr_en}} & ~i_hard_mask;
`else
  assign hard_elig = pending_q[HARD_SRC_NUM-1:0] & {HARD_SRC_NUM{i_intr_en}};
`endif
  assign soft_elig = pending_q[SRC_N-1:HARD_SRC_NUM];

  intr_priority_enc #(
    .HARD_N (HARD_SRC_NUM),
    .SOFT_N (SOFT_SRC_NUM)
  ) u_prio (
    .hard_elig (hard_elig),
    .soft_elig (soft_elig),
    .hard_code (enc_h_code),
    .soft_code (enc_s_code),
    .winner    (enc_winner)
  );

  // Clear the served bit first, then OR in new events so a same-cycle set wins.
  assign pending_d = (pending_q & ~clr) | {i_soft_exc, hard_edge};

  // Next-state and next-output logic of the request/service sequencer.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    svc_d    = svc_q;
    h_code_d = h_code_q;
    s_code_d = s_code_q;
    winner_d = winner_q;
    clr      = '0;
    case (state_q)
      ST_RST: begin
        req_d    = 1'b1;
        h_code_d = HC_RESET;
        s_code_d = SC_NONE;
        state_d  = ST_REQ_RST;
      end
      ST_REQ_RST: begin
        if (cpu.intr_ack) begin
          req_d    = 1'b0;
          h_code_d = HC_NONE;
          s_code_d = SC_NONE;
          svc_d    = 1'b1;
          state_d  = ST_SERVICE;
        end
      end
      ST_IDLE: begin
        if (|enc_winner) begin
          req_d    = 1'b1;
          h_code_d = enc_h_code;
          s_code_d = enc_s_code;
          winner_d = enc_winner;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // The latched winner is held; nothing that arrives later preempts it.
        if (cpu.intr_ack) begin
          clr      = winner_q;
          req_d    = 1'b0;
          h_code_d = HC_NONE;
          s_code_d = SC_NONE;
          svc_d    = 1'b1;
          state_d  = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (i_eret) begin
          svc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!i_rst_n) state_q <= ST_RST;
    else          state_q <= state_d;
  end

  // Registered handshake outputs, latched winner, pending bits and edge history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q       <= 1'b0;
      svc_q       <= 1'b0;
      h_code_q    <= HC_NONE;
      s_code_q    <= SC_NONE;
      winner_q    <= '0;
      pending_q   <= '0;
      hard_prev_q <= '0;
    end else begin
      req_q       <= req_d;
      svc_q       <= svc_d;
      h_code_q    <= h_code_d;
      s_code_q    <= s_code_d;
      winner_q    <= winner_d;
      pending_q   <= pending_d;
      hard_prev_q <= i_hard_irq;
    end
  end

  assign cpu.intr_req    = req_q;
  assign cpu.in_service  = svc_q;
  assign cpu.h_intr_code = h_code_q;
  assign cpu.s_intr_code = s_code_q;
  assign o_pending       = pending_q;

endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
- Interrupt/exception front end, directly upstream of the interrupt vector address decoder.
- Latches hardware interrupt events (timer, keyboard, ethernet, IO) and synchronous software exceptions (zerodiv, overflow, underflow, trap).
- Arbitrates between them and presents exactly one exception code at a time, with a req/ack handshake to the CPU sequencer.
- Tracks the in-service state until return-from-interrupt; issues the RESET code once after reset release.

Parameters:
- HARD_SRC_NUM, 4, number of maskable hardware sources (timer, keyboard, ethernet, io, in priority order).
- SOFT_SRC_NUM, 4, number of software exception sources (zerodiv, overflow, underflow, trap, in priority order).

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous active-low reset; single clock domain.
- i_hard_irq  in  HARD_SRC_NUM  level hardware requests, synchronous to i_clk; bit0=timer, 1=keyboard, 2=ethernet, 3=io.
- i_soft_exc  in  SOFT_SRC_NUM  one-cycle exception pulses from execute stage; bit0=zerodiv, 1=overflow, 2=underflow, 3=trap.
- i_intr_en  in  1  global enable for hardware sources; soft exceptions and RESET are not maskable.
- i_intr_ack  in  1  CPU has taken the vector; valid only while o_intr_req=1.
- i_eret  in  1  one-cycle pulse: return from handler.
- o_intr_req  out  1  request to CPU.
- o_h_intr_code  out  `EXCEPTION_CODE_HARD_BITS  hardware code to decoder.
- o_s_intr_code  out  `EXCEPTION_CODE_SOFT_BITS  software code to decoder.
- o_in_service  out  1  handler running.
- o_pending  out  HARD_SRC_NUM+SOFT_SRC_NUM  raw pending bits, hard bits in the low positions.

Behaviour:
- Code values (define.v): hard NONE=0, RESET=1, TIMER=2, KEYBOARD=3, ETHERNET=4, IO=5; soft NONE=0, ZERODIV=1, OVERFLOW=2, UNDERFLOW=3, TRAP=4.
- Reset values: o_intr_req=0, both codes NONE, o_in_service=0, all pending=0, state=RST.
- Hard pending bit sets on rising edge of i_hard_irq[k] (registered previous value; previous value resets to 0). Soft pending bit sets on i_soft_exc[k]=1.
- Pending bits set regardless of state or enable.
- A set and a clear of the same bit in one cycle: set wins, bit stays 1.
- Candidate priority: timer > keyboard > ethernet > io > zerodiv > overflow > underflow > trap.
- Hard candidates are eligible only if i_intr_en=1; soft candidates are always eligible.
- FSM:
  - RST: entered on reset. First clock after release drives req=1, hard=RESET → REQ_RST.
  - REQ_RST: hold until ack → SERVICE (in_service=1).
  - IDLE: if any eligible pending, register winner code (other field NONE), req=1 next cycle → REQ.
  - REQ: code and req held stable until i_intr_ack. On ack: clear winner's pending bit, req=0, codes→NONE, in_service=1 → SERVICE. Later-arriving higher-priority pending does not preempt a held request.
  - SERVICE: no new requests. i_eret → IDLE, in_service=0. An eligible pending may raise req on the cycle after IDLE entry.
- Latency: edge in cycle N → pending=1 at N+1 → req=1 at N+2 (IDLE, enabled).
- i_intr_ack outside REQ/REQ_RST and i_eret outside SERVICE are ignored.
- i_intr_en drop while in REQ with a hard code: the request is still held (no retraction).
- Async reset mid-operation: everything returns to reset values immediately; RESET code is reissued.

Optional Feature:
- Macro: INTR_SOURCE_MASK_EN.
- Defined: adds port i_hard_mask, in, HARD_SRC_NUM bits. Bit=1 makes that hard source ineligible; its pending bit is still latched, visible on o_pending, and taken once unmasked.
- Undefined: port absent; all hard sources eligible subject only to i_intr_en.

Decomposition:
- define.v: code widths, all EXCEPTION_CODE_* values (including NONE), FSM state encodings, source bit indices.
- One natural sub-module: intr_priority_enc. Combinational; maps eligible pending vector to {hard code, soft code, one-hot winner}.

Test Plan:
- Release reset → req=1, hard=1 (RESET), soft=0 in first cycle after release; ack → in_service=1; eret → IDLE, req=0.
- i_intr_en=1, pulse timer and io in the same cycle → req with hard=2; ack+eret → next req hard=5; ack clears; o_pending=0.
- i_intr_en=0, keyboard edge plus zerodiv pulse → req soft=1, hard=0; keyboard stays pending until en=1, then req hard=3.
- Trap pulse during SERVICE → no req until eret; req soft=4 one cycle after IDLE entry.
- Timer edge in the same cycle as ack of timer → pending stays 1; timer re-requested after eret.
- Async reset asserted in REQ (hard=4) → req=0, codes 0, pending 0 immediately; RESET reissued after release.
